// File: rtl/mesh_pkg.sv
// Shared mesh definitions: default mesh dimensions, width helpers and entry width.
package mesh_pkg;

  localparam int DEF_X_SIZE = 8;
  localparam int DEF_Y_SIZE = 8;
  localparam int DEF_W      = 32;

  // Index width for a range of n values, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Coordinate field width for a mesh dimension of the given size.
  function automatic int coord_w(input int size);
    return idx_w(size);
  endfunction

  // Stored entry width: {dst_x, dst_y, payload}.
  function automatic int entry_w(input int xw, input int yw, input int w);
    return xw + yw + w;
  endfunction

endpackage

// File: rtl/mesh_fifo_wr_compact.sv
// Write compaction: packs the valid sources, in ascending index order, onto
// consecutive write slots. Slot j is written at wr_ptr+j and takes source slot_sel[j].
module mesh_fifo_wr_compact
  import mesh_pkg::*;
#(
  parameter  int N_IN = 4,
  localparam int SW   = idx_w(N_IN),
  localparam int NW   = $clog2(N_IN + 1)
) (
  input  logic [N_IN-1:0]         valid,
  output logic [N_IN-1:0]         slot_en,
  output logic [N_IN-1:0][SW-1:0] slot_sel,
  output logic [NW-1:0]           push_cnt
);

  logic [NW-1:0] rank [N_IN];

  // Rank of each source = number of valid sources below it; that rank is its slot.
  always_comb begin
    slot_en  = '0;
    slot_sel = '0;
    rank[0]  = '0;
    for (int k = 1; k < N_IN; k++) begin
      rank[k] = rank[k-1] + NW'(valid[k-1]);
    end
    for (int j = 0; j < N_IN; j++) begin
      for (int k = 0; k < N_IN; k++) begin
        if (valid[k] && (rank[k] == NW'(j))) begin
          slot_en[j]  = 1'b1;
          slot_sel[j] = SW'(k);
        end
      end
    end
    push_cnt = rank[N_IN-1] + NW'(valid[N_IN-1]);
  end

endmodule

// File: rtl/mesh_nport_fifo.sv
// Multi-writer, single-reader flit FIFO for a mesh router output port.
// All flits presented in one cycle are enqueued together in source index order.
// Define MESH_FIFO_ASSERT_EN to enable simulation-only consistency checks.
module mesh_nport_fifo
  import mesh_pkg::*;
#(
  parameter  int W            = DEF_W,
  parameter  int X_SIZE       = DEF_X_SIZE,
  parameter  int Y_SIZE       = DEF_Y_SIZE,
  parameter  int BUFFER_DEPTH = 4,
  parameter  int N_IN         = 4,
  localparam int XW           = coord_w(X_SIZE),
  localparam int YW           = coord_w(Y_SIZE)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_IN-1:0]   i_valid,
  input  logic [N_IN*XW-1:0] i_dst_x,
  input  logic [N_IN*YW-1:0] i_dst_y,
  input  logic [N_IN*W-1:0] i_payload,
  output logic              i_ready,
  output logic              o_valid,
  output logic [XW-1:0]     o_dst_x,
  output logic [YW-1:0]     o_dst_y,
  output logic [W-1:0]      o_payload,
  input  logic              o_ready
);

  localparam int EW = entry_w(XW, YW, W);
  localparam int PW = idx_w(BUFFER_DEPTH);
  localparam int CW = $clog2(BUFFER_DEPTH + 1);
  localparam int SW = idx_w(N_IN);
  localparam int NW = $clog2(N_IN + 1);

  logic [EW-1:0]           mem [BUFFER_DEPTH];
  logic [PW-1:0]           wr_ptr;
  logic [PW-1:0]           rd_ptr;
  logic [CW-1:0]           count;
  logic [N_IN-1:0]         slot_en;
  logic [N_IN-1:0][SW-1:0] slot_sel;
  logic [NW-1:0]           push_cnt;
  logic [EW-1:0]           src_entry  [N_IN];
  logic [EW-1:0]           slot_entry [N_IN];
  logic [PW-1:0]           slot_addr  [N_IN];
  logic                    push;
  logic                    pop;

  // Pointer advance with an explicit wrap compare, so non power-of-two depths work.
  // inc never exceeds BUFFER_DEPTH, so one subtraction is enough.
  function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] base, input int inc);
    logic [PW:0] sum;
    sum = {1'b0, base} + (PW+1)'(inc);
    if (sum > (PW+1)'(BUFFER_DEPTH - 1)) begin
      sum = sum - (PW+1)'(BUFFER_DEPTH);
    end
    return sum[PW-1:0];
  endfunction

  mesh_fifo_wr_compact #(
    .N_IN (N_IN)
  ) u_wr_compact (
    .valid    (i_valid),
    .slot_en  (slot_en),
    .slot_sel (slot_sel),
    .push_cnt (push_cnt)
  );

  // Unpack each source into a full entry.
  always_comb begin
    for (int k = 0; k < N_IN; k++) begin
      src_entry[k] = {i_dst_x[k*XW +: XW], i_dst_y[k*YW +: YW], i_payload[k*W +: W]};
    end
  end

  // Route the selected source and the wrapped address to every write slot.
  always_comb begin
    for (int j = 0; j < N_IN; j++) begin
      slot_entry[j] = src_entry[slot_sel[j]];
      slot_addr[j]  = ptr_add(wr_ptr, j);
    end
  end

  // Ready depends on registered count only; a same-cycle pop is not credited.
  assign i_ready = (32'(count) + 32'(N_IN)) <= 32'(BUFFER_DEPTH);
  assign push    = i_ready && (push_cnt != '0);
  assign o_valid = (count != '0);
  assign pop     = o_valid && o_ready;
  assign {o_dst_x, o_dst_y, o_payload} = mem[rd_ptr];

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= ptr_add(wr_ptr, 32'(push_cnt));
      end
      if (pop) begin
        rd_ptr <= ptr_add(rd_ptr, 1);
      end
      count <= count + (push ? CW'(push_cnt) : CW'(0)) - CW'(pop);
    end
  end

  // Entry storage; reset clears it so the head outputs read zero after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BUFFER_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push) begin
      for (int j = 0; j < N_IN; j++) begin
        if (slot_en[j]) begin
          mem[slot_addr[j]] <= slot_entry[j];
        end
      end
    end
  end

`ifdef MESH_FIFO_ASSERT_EN
  logic [W-1:0] payload_q;

  // Parameter sanity at time zero.
  initial begin
    if (BUFFER_DEPTH < N_IN) begin
      $error("%0t mesh_nport_fifo: BUFFER_DEPTH %0d smaller than N_IN %0d", $time, BUFFER_DEPTH, N_IN);
    end
  end

  // Occupancy bound and empty-head stability.
  always @(posedge clk) begin
    payload_q <= o_payload;
    if (rst_n && (32'(count) > 32'(BUFFER_DEPTH))) begin
      $error("%0t mesh_nport_fifo: count %0d exceeds depth", $time, count);
    end
    if (rst_n && o_ready && !o_valid && (o_payload != payload_q)) begin
      $error("%0t mesh_nport_fifo: head payload changed while empty", $time);
    end
  end
`endif

endmodule

// File: tb/tb_mesh_nport_fifo.sv
// Bench for mesh_nport_fifo: three instances (4 ports depth 4, 2 ports depth 4,
// 2 ports depth 5) checked every cycle against queue-based reference models.
module tb_mesh_nport_fifo;

  logic clk;
  logic rst_n;

  logic [3:0]   a_iv;
  logic [11:0]  a_dx, a_dy;
  logic [127:0] a_pl;
  logic         a_ir, a_ov, a_or;
  logic [2:0]   a_ox, a_oy;
  logic [31:0]  a_op;

  logic [1:0]   b_iv;
  logic [5:0]   b_dx, b_dy;
  logic [63:0]  b_pl;
  logic         b_or;
  logic         b_ir, b_ov;
  logic [2:0]   b_ox, b_oy;
  logic [31:0]  b_op;
  logic         c_ir, c_ov;
  logic [2:0]   c_ox, c_oy;
  logic [31:0]  c_op;

  logic [37:0] qa[$];
  logic [37:0] qb[$];
  logic [37:0] qc[$];

  int n_checks = 0;
  int n_errors = 0;

  mesh_nport_fifo #(.W(32), .X_SIZE(8), .Y_SIZE(8), .BUFFER_DEPTH(4), .N_IN(4)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .i_valid(a_iv), .i_dst_x(a_dx), .i_dst_y(a_dy),
    .i_payload(a_pl), .i_ready(a_ir), .o_valid(a_ov), .o_dst_x(a_ox), .o_dst_y(a_oy),
    .o_payload(a_op), .o_ready(a_or)
  );

  mesh_nport_fifo #(.W(32), .X_SIZE(8), .Y_SIZE(8), .BUFFER_DEPTH(4), .N_IN(2)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .i_valid(b_iv), .i_dst_x(b_dx), .i_dst_y(b_dy),
    .i_payload(b_pl), .i_ready(b_ir), .o_valid(b_ov), .o_dst_x(b_ox), .o_dst_y(b_oy),
    .o_payload(b_op), .o_ready(b_or)
  );

  mesh_nport_fifo #(.W(32), .X_SIZE(8), .Y_SIZE(8), .BUFFER_DEPTH(5), .N_IN(2)) u_dut_c (
    .clk(clk), .rst_n(rst_n), .i_valid(b_iv), .i_dst_x(b_dx), .i_dst_y(b_dy),
    .i_payload(b_pl), .i_ready(c_ir), .o_valid(c_ov), .o_dst_x(c_ox), .o_dst_y(c_oy),
    .o_payload(c_op), .o_ready(b_or)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Compare every instance against its model's current contents.
  task automatic check_models();
    chk("a_ready", a_ir, (4 - qa.size()) >= 4);
    chk("a_valid", a_ov, qa.size() != 0);
    if (qa.size() != 0) chk("a_head", {a_ox, a_oy, a_op}, qa[0]);
    chk("b_ready", b_ir, (4 - qb.size()) >= 2);
    chk("b_valid", b_ov, qb.size() != 0);
    if (qb.size() != 0) chk("b_head", {b_ox, b_oy, b_op}, qb[0]);
    chk("c_ready", c_ir, (5 - qc.size()) >= 2);
    chk("c_valid", c_ov, qc.size() != 0);
    if (qc.size() != 0) chk("c_head", {c_ox, c_oy, c_op}, qc[0]);
  endtask

  // One clock: check, then apply the queue rules to the inputs held across the edge.
  task automatic tick();
    bit ra, pa, rb, pb, rc, pc;
    check_models();
    ra = (4 - qa.size()) >= 4;
    pa = (qa.size() != 0) && a_or;
    rb = (4 - qb.size()) >= 2;
    pb = (qb.size() != 0) && b_or;
    rc = (5 - qc.size()) >= 2;
    pc = (qc.size() != 0) && b_or;
    @(posedge clk);
    if (pa) void'(qa.pop_front());
    if (pb) void'(qb.pop_front());
    if (pc) void'(qc.pop_front());
    for (int k = 0; k < 4; k++) begin
      if (ra && a_iv[k]) qa.push_back({a_dx[k*3 +: 3], a_dy[k*3 +: 3], a_pl[k*32 +: 32]});
    end
    for (int k = 0; k < 2; k++) begin
      if (rb && b_iv[k]) qb.push_back({b_dx[k*3 +: 3], b_dy[k*3 +: 3], b_pl[k*32 +: 32]});
      if (rc && b_iv[k]) qc.push_back({b_dx[k*3 +: 3], b_dy[k*3 +: 3], b_pl[k*32 +: 32]});
    end
    @(negedge clk);
  endtask

  task automatic rand_inputs();
    a_iv = 4'($urandom());
    a_dx = 12'($urandom());
    a_dy = 12'($urandom());
    a_pl = {$urandom(), $urandom(), $urandom(), $urandom()};
    a_or = ($urandom_range(0, 3) != 0);
    b_iv = 2'($urandom());
    b_dx = 6'($urandom());
    b_dy = 6'($urandom());
    b_pl = {$urandom(), $urandom()};
    b_or = ($urandom_range(0, 3) != 0);
  endtask

  task automatic idle_inputs();
    a_iv = '0;
    b_iv = '0;
    a_or = 1'b1;
    b_or = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    a_iv = '0; a_dx = '0; a_dy = '0; a_pl = '0; a_or = 1'b0;
    b_iv = '0; b_dx = '0; b_dy = '0; b_pl = '0; b_or = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Reset state
    chk("rst_a_valid", a_ov, 1'b0);
    chk("rst_a_ready", a_ir, 1'b1);
    chk("rst_a_payload", a_op, 32'h0);
    chk("rst_b_valid", b_ov, 1'b0);
    chk("rst_b_ready", b_ir, 1'b1);
    tick();

    // Four-way burst into a 4-deep queue
    a_iv = 4'hF;
    a_dx = {3'd3, 3'd2, 3'd1, 3'd0};
    a_dy = {3'd7, 3'd6, 3'd5, 3'd4};
    a_pl = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    a_or = 1'b0;
    tick();
    a_iv = '0;
    a_or = 1'b1;
    chk("burst_ready_low", a_ir, 1'b0);
    chk("burst_valid", a_ov, 1'b1);
    for (int i = 0; i < 4; i++) begin
      chk("burst_order", a_op, 32'hA0 + i);
      tick();
    end
    chk("burst_empty", a_ov, 1'b0);
    chk("burst_ready_back", a_ir, 1'b1);

    // Sparse push compacts without gaps
    a_or = 1'b0;
    a_iv = 4'b1010;
    a_pl = {32'h33, 32'hDEAD, 32'h11, 32'hBEEF};
    tick();
    a_iv = '0;
    chk("sparse_head", a_op, 32'h11);
    chk("sparse_ready", a_ir, 1'b0);
    a_or = 1'b1;
    tick();
    chk("sparse_second", a_op, 32'h33);
    tick();
    chk("sparse_empty", a_ov, 1'b0);

    // Continuous single pushes through the 2-port queues, wrapping pointers
    b_or = 1'b1;
    for (int i = 0; i < 20; i++) begin
      b_iv = 2'b01;
      b_pl = {32'hFFFF_FFFF, 32'(i)};
      tick();
      chk("stream_b", b_op, 32'(i));
      chk("stream_c", c_op, 32'(i));
    end
    b_iv = '0;
    tick();
    chk("stream_b_empty", b_ov, 1'b0);

    // Backpressure: fill with two pairs, further flits refused, head stable
    b_or = 1'b0;
    b_iv = 2'b11;
    b_pl = {32'h51, 32'h50};
    tick();
    chk("bp_ready_after_pair", b_ir, 1'b1);
    b_pl = {32'h53, 32'h52};
    tick();
    chk("bp_ready_full", b_ir, 1'b0);
    b_pl = {32'h55, 32'h54};
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_head_stable", b_op, 32'h50);
      chk("bp_ready_held", b_ir, 1'b0);
    end
    b_iv = '0;
    b_or = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("bp_drain", b_op, 32'h50 + i);
      tick();
    end
    chk("bp_drained", b_ov, 1'b0);

    // Randomized traffic on all instances
    for (int n = 0; n < 400; n++) begin
      rand_inputs();
      tick();
    end
    idle_inputs();
    repeat (6) tick();

    // Asynchronous reset in the middle of a drain
    a_or = 1'b0;
    a_iv = 4'hF;
    a_pl = {32'h63, 32'h62, 32'h61, 32'h60};
    tick();
    a_iv = '0;
    a_or = 1'b1;
    tick();
    chk("mid_head", a_op, 32'h61);
    chk("mid_valid", a_ov, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_valid", a_ov, 1'b0);
    chk("async_payload", a_op, 32'h0);
    chk("async_ready", a_ir, 1'b1);
    qa.delete();
    qb.delete();
    qc.delete();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    a_iv = 4'b0100;
    a_pl = {32'h0, 32'h77, 32'h0, 32'h0};
    a_or = 1'b0;
    tick();
    a_iv = '0;
    chk("post_rst_first", a_op, 32'h77);
    chk("post_rst_valid", a_ov, 1'b1);

    for (int n = 0; n < 100; n++) begin
      rand_inputs();
      tick();
    end
    idle_inputs();
    repeat (6) tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
